// File: rtl/dmem_bytelane_if.sv
// Request/response bus for the mem-stage data memory.
// One request per cycle in, one response pulse a cycle later.
interface dmem_bytelane_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory for the mem stage: RV loads/stores,
// error checks, 1-cycle response, sequential clear after reset.
module dmem_bytelane #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_bytelane_if.slave bus,
  output logic           busy
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t         state;
  logic [IW-1:0]  cnt;
  logic           ready_q;
  logic           busy_q;
  logic           rv_q;
  logic           re_q;
  logic [31:0]    rd_q;

  logic [31:0]    mem [DEPTH];

  logic           acc;
  logic           err;
  logic           oor;
  logic [IW-1:0]  idx;
  logic [1:0]     off;
  logic [3:0]     be;
  logic [31:0]    wrep;
  logic [31:0]    word;
  logic [7:0]     bsel;
  logic [15:0]    hsel;
  logic [31:0]    ld;

  assign idx  = bus.req_addr[IW+1:2];
  assign off  = bus.req_addr[1:0];
  assign oor  = (bus.req_addr >> (IW + 2)) != '0;
  assign acc  = bus.req_valid & ready_q;
  assign word = mem[idx];
  assign bsel = word[{off, 3'b000} +: 8];
  assign hsel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    err  = oor;
    be   = 4'b0000;
    wrep = bus.req_wdata;
    ld   = word;
    unique case (1'b1)
      bus.req_size == 2'b00: begin
        be   = 4'b0001 << off;
        wrep = {4{bus.req_wdata[7:0]}};
        ld   = bus.req_unsigned ? {24'h0, bsel}
                                : {{24{bsel[7]}}, bsel};
      end
      bus.req_size == 2'b01: begin
        err  = oor | off[0];
        be   = 4'b0011 << off;
        wrep = {2{bus.req_wdata[15:0]}};
        ld   = bus.req_unsigned ? {16'h0, hsel}
                                : {{16{hsel[15]}}, hsel};
      end
      bus.req_size == 2'b10: begin
        err  = oor | (off != 2'b00);
        be   = 4'b1111;
      end
      default: err = 1'b1;
    endcase
  end

  // Clear engine and stores share the single write port
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (acc && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt     <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RESET != 0);
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      rv_q <= acc;
      re_q <= acc & err;
      rd_q <= (acc && !err && !bus.req_we) ? ld : '0;
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) begin
            state   <= READY;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        READY: ready_q <= 1'b1;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_err   = re_q;
  assign bus.rsp_rdata = rd_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: directed scenarios plus random
// traffic against a byte-array reference model.
module tb_dmem_bytelane;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst0 = 1'b0;
  logic busy, busy0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_bytelane_if #(.ADDR_W(32)) bi ();
  dmem_bytelane_if #(.ADDR_W(32)) bi0 ();

  dmem_bytelane #(
    .DEPTH(256), .ADDR_W(32), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bi.slave), .busy(busy)
  );

  dmem_bytelane #(
    .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bi0.slave), .busy(busy0)
  );

  logic [7:0] mref [1024];

  function automatic void model(
    input logic we, input logic [31:0] a, input logic [31:0] wd,
    input logic [1:0] sz, input logic u,
    output logic e, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
        (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd1024);
    rd = 32'h0;
    if (e) return;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (we) mref[a + i] = wd[8*i +: 8];
      else v = v | (32'(mref[a + i]) << (8 * i));
    end
    if (we) return;
    if (sz == 2'd0)
      rd = u ? v : {{24{v[7]}}, v[7:0]};
    else if (sz == 2'd1)
      rd = u ? v : {{16{v[15]}}, v[15:0]};
    else
      rd = v;
  endfunction

  task automatic xfer(
    input bit sel, input logic we, input logic [31:0] a,
    input logic [31:0] wd, input logic [1:0] sz, input logic u,
    output logic v, output logic [31:0] rd, output logic e);
    if (!sel) begin
      bi.req_valid = 1'b1; bi.req_we = we; bi.req_addr = a;
      bi.req_wdata = wd; bi.req_size = sz; bi.req_unsigned = u;
    end else begin
      bi0.req_valid = 1'b1; bi0.req_we = we; bi0.req_addr = a;
      bi0.req_wdata = wd; bi0.req_size = sz; bi0.req_unsigned = u;
    end
    @(posedge clk); #1;
    bi.req_valid = 1'b0;
    bi0.req_valid = 1'b0;
    if (!sel) begin
      v = bi.rsp_valid; rd = bi.rsp_rdata; e = bi.rsp_err;
    end else begin
      v = bi0.rsp_valid; rd = bi0.rsp_rdata; e = bi0.rsp_err;
    end
  endtask

  task automatic run(
    input logic we, input logic [31:0] a, input logic [31:0] wd,
    input logic [1:0] sz, input logic u,
    output logic v, output logic [31:0] rd, output logic e,
    output logic xe, output logic [31:0] xrd);
    model(we, a, wd, sz, u, xe, xrd);
    xfer(1'b0, we, a, wd, sz, u, v, rd, e);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    bit bad = 0;
    while (!bi.req_ready && n < 1000) begin
      if (busy !== 1'b1) bad = 1;
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL %s_len: got %0d cycles want 256", tag, n);
    end
    n_chk++;
    if (bad || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got bad=%0d busy=%b want 0/0",
               tag, bad, busy);
    end
    for (int i = 0; i < 1024; i++) mref[i] = 8'h0;
  endtask

  task automatic test_reset;
    logic v, e, xe;
    logic [31:0] rd, xrd;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, bi.req_ready, bi.rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_state: got %b want 100",
               {busy, bi.req_ready, bi.rsp_valid});
    end
    rst = 1'b1;
    wait_clear("clear");
    run(1'b0, 32'h3FC, 32'h0, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL lw_3fc: got v=%b e=%b %h want 1 0 0", v, e, rd);
    end
  endtask

  task automatic test_loads;
    logic [31:0] la [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
    logic [1:0]  ls [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        lu [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] lx [5] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                            32'hFFFF80FF, 32'h000080FF};
    logic v, e, xe;
    logic [31:0] rd, xrd;
    run(1'b1, 32'h10, 32'h80FF7F01, 2'd2, 1'b0, v, rd, e, xe, xrd);
    for (int i = 0; i < 5; i++) begin
      run(1'b0, la[i], 32'h0, ls[i], lu[i], v, rd, e, xe, xrd);
      n_chk++;
      if ({v, e, rd} !== {2'b10, lx[i]}) begin
        n_fail++;
        $display("FAIL load%0d: got v=%b e=%b %h want 1 0 %h",
                 i, v, e, rd, lx[i]);
      end
    end
    bi.req_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_err, bi.rsp_rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL idle: got v=%b e=%b %h want 0 0 0",
               bi.rsp_valid, bi.rsp_err, bi.rsp_rdata);
    end
  endtask

  task automatic test_stores;
    logic v, e, xe;
    logic [31:0] rd, xrd;
    run(1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL sw_rsp: got v=%b e=%b %h want 1 0 0", v, e, rd);
    end
    run(1'b1, 32'h21, 32'hFFFFFFAA, 2'd0, 1'b0, v, rd, e, xe, xrd);
    run(1'b1, 32'h22, 32'h0000BEEF, 2'd1, 1'b0, v, rd, e, xe, xrd);
    run(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'hBEEFAA44}) begin
      n_fail++;
      $display("FAIL merge: got %h want beefaa44", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] ea [8] = '{32'h1, 32'h2, 32'h0, 32'h400,
                            32'h1, 32'h2, 32'h0, 32'h400};
    logic [1:0]  es [8] = '{2'd1, 2'd2, 2'd3, 2'd2,
                            2'd1, 2'd2, 2'd3, 2'd2};
    logic v, e, xe;
    logic [31:0] rd, xrd;
    run(1'b1, 32'h0, 32'hCAFEF00D, 2'd2, 1'b0, v, rd, e, xe, xrd);
    for (int i = 0; i < 8; i++) begin
      run(i >= 4, ea[i], 32'h55555555, es[i], 1'b0,
          v, rd, e, xe, xrd);
      n_chk++;
      if ({v, e, rd} !== {2'b11, 32'h0}) begin
        n_fail++;
        $display("FAIL err%0d: got v=%b e=%b %h want 1 1 0",
                 i, v, e, rd);
      end
    end
    run(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL err_nowrite: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic v, e, xe;
    logic [31:0] rd, xrd;
    run(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, rd} !== {1'b1, 32'h80FF7F01}) begin
      n_fail++;
      $display("FAIL mid_pre: got v=%b %h want 1 80ff7f01", v, rd);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bi.rsp_valid, busy, bi.req_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_rst: got %b want 010",
               {bi.rsp_valid, busy, bi.req_ready});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_clear("reclear");
    run(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, v, rd, e, xe, xrd);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_zero: got %h want 0", rd);
    end
  endtask

  task automatic test_random;
    logic v, e, xe, we, u;
    logic [31:0] rd, xrd, a;
    logic [1:0] sz;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? $urandom
                                       : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      run(we, a, $urandom, sz, u, v, rd, e, xe, xrd);
      n_chk++;
      if ({v, e, rd} !== {1'b1, xe, xrd}) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL rnd%0d: a=%h sz=%0d we=%b got e=%b %h want e=%b %h",
                   i, a, sz, we, e, rd, xe, xrd);
      end
    end
  endtask

  task automatic test_no_clear;
    logic v, e;
    logic [31:0] rd;
    n_chk++;
    if ({busy0, bi0.req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL nc_rst: got %b want 00", {busy0, bi0.req_ready});
    end
    rst0 = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy0, bi0.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL nc_ready: got %b want 01", {busy0, bi0.req_ready});
    end
    xfer(1'b1, 1'b1, 32'h8, 32'h12345678, 2'd2, 1'b0, v, rd, e);
    xfer(1'b1, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, v, rd, e);
    n_chk++;
    if ({v, e, rd} !== {2'b10, 32'h12345678}) begin
      n_fail++;
      $display("FAIL nc_rt: got v=%b e=%b %h want 1 0 12345678", v, e, rd);
    end
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, v, rd, e);
    n_chk++;
    if ({v, e, rd} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL nc_oor: got v=%b e=%b %h want 1 1 0", v, e, rd);
    end
  endtask

  initial begin
    bi.req_valid = 1'b0; bi.req_we = 1'b0; bi.req_addr = '0;
    bi.req_wdata = '0; bi.req_size = '0; bi.req_unsigned = 1'b0;
    bi0.req_valid = 1'b0; bi0.req_we = 1'b0; bi0.req_addr = '0;
    bi0.req_wdata = '0; bi0.req_size = '0; bi0.req_unsigned = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid();
    test_random();
    test_no_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised single-port data memory for the mem stage of the pipelined core.
- Replaces the fixed 32x32 word array with:
  - configurable depth;
  - RISC-V byte/half/word loads and stores with sign/zero extension;
  - misalign and range error reporting;
  - a valid/ready request port with a 1-cycle response;
  - a sequential clear engine that zeroes the array after reset, instead of a whole-array assignment.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 4..4096.
- ADDR_W, 32, width of the byte address on req_addr.
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset; when 0 that step is skipped.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU).
- rsp_valid  output  1  response pulse, one cycle after acceptance.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, out of range, or used an illegal size.
- busy  output  1  clear engine running.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = CLEAR if CLEAR_ON_RESET = 1, else READY;
  - clear counter = 0; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 and busy = CLEAR_ON_RESET while reset is asserted.
  - A pending response is discarded; no write occurs.
- CLEAR state:
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After writing word DEPTH-1, moves to READY. That is DEPTH cycles after the first clk edge with rst = 1.
  - busy = 1 and req_ready = 0 throughout; req_valid is ignored.
- READY state: req_ready = 1 and busy = 0; the state persists until reset.
- Acceptance: a request is accepted at a clk edge where req_valid & req_ready.
  - One request per cycle; back-to-back accepts are allowed; no bubbles.
- Decode:
  - word index = req_addr[log2(DEPTH)+1 : 2];
  - byte offset = req_addr[1:0].
- Error, evaluated combinationally at acceptance. Set if any of:
  - req_size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00;
  - req_addr[ADDR_W-1 : log2(DEPTH)+2] nonzero (out of range).
- On error:
  - no memory write occurs;
  - the response is rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Store (no error):
  - At the accept edge, writes only the selected byte lanes: byte → lane offset; half → lanes offset, offset+1; word → all 4.
  - Data is replicated so that req_wdata[7:0] / [15:0] lands in the addressed lanes. Other lanes are unchanged.
  - Next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Load (no error):
  - The word is read at the accept edge.
  - The next cycle presents the lane-selected data, sign- or zero-extended to 32 bits per req_unsigned. Word loads ignore req_unsigned.
  - rsp_valid = 1 for exactly that cycle.
- Latency: exactly 1 cycle from accept to rsp_valid. No back-pressure on the response side.
- Store followed by load to the same word on the next cycle: the load returns the newly stored bytes, since the write commits at the store's accept edge.
- rsp_valid = 0 in any cycle not following an accept. While rsp_valid = 0, rsp_rdata and rsp_err hold 0.
- Reset during CLEAR restarts the counter at 0. Reset in READY returns to CLEAR (if enabled); memory contents are not guaranteed until the clear completes.

Test Plan:
- Reset, then release with CLEAR_ON_RESET = 1, DEPTH = 256 → busy = 1 and req_ready = 0 for exactly 256 cycles, then req_ready = 1. A load from 0x3FC returns 0x00000000, err = 0.
- SW 0x80FF7F01 @0x10, then back-to-back LB @0x10, LB @0x13, LBU @0x13, LH @0x12, LHU @0x12 → rdata = 0x00000001, 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF. Each response arrives 1 cycle after its accept.
- SW 0x11223344 @0x20; SB 0xAA @0x21; SH 0xBEEF @0x22; LW @0x20 next cycle → 0xBEEFAA44.
- LH @0x01, LW @0x02, size = 11 @0x00, LW @0x400 (DEPTH = 256) → each gives rsp_err = 1, rdata = 0. A following LW @0x00 returns the unchanged prior contents; none of these requests wrote.
- Assert rst mid-stream, one cycle after an accepted load → rsp_valid = 0 immediately (asynchronous), no response pulse, busy = 1, and the clear restarts from word 0.
- CLEAR_ON_RESET = 0 → req_ready = 1 on the first edge after reset release; a store-then-load round trip works on the next cycle.
